// File: rtl/uart_bridge_pkg.sv
// Shared opcodes, response codes and parser states for the UART-to-register-bus bridge.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h57;
  localparam logic [7:0] OP_READ     = 8'h52;
  localparam logic [7:0] RSP_OK      = 8'h2B;
  localparam logic [7:0] RSP_BADOP   = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h21;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/uart_bus_bridge.sv
// Parses binary read/write frames from the rx FIFO, runs one register-bus
// transaction per frame and pushes the response bytes into the tx FIFO.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 16,
  parameter logic [23:0] IDLE_TIMEOUT = 24'd1000000,
  parameter logic [15:0] BUS_TIMEOUT  = 16'd1024
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic [7:0]            rx_fifo_rd_data,
  input  logic                  rx_fifo_ne,
  output logic                  rx_fifo_re,
  input  logic                  uart_frame_error,
  output logic [7:0]            tx_fifo_wr_data,
  output logic                  tx_fifo_we,
  input  logic                  tx_fifo_full,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata
);

  state_t      state, state_d;
  logic        pop_block;
  logic [23:0] idle_cnt;
  logic [15:0] bus_cnt;
  logic [1:0]  byte_cnt;
  logic [15:0] addr_raw;
  logic [31:0] resp_buf;
  logic [2:0]  resp_left;
  logic        frame_st;
  logic        abort_err;
  logic        idle_expired;
  logic        ack_hit;
  logic        bus_expired;

  assign frame_st    = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
  assign abort_err   = frame_st && uart_frame_error;
  assign ack_hit     = (state == BUS) && bus_req && bus_ack;
  assign bus_expired = (state == BUS) && bus_req && !bus_ack && (bus_cnt == BUS_TIMEOUT - 16'd1);
  assign bus_addr    = ADDR_WIDTH'(addr_raw);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_d;
  end

  // A frame error withholds the pop so the errored byte is re-read as an opcode.
  always_comb begin
    state_d         = state;
    rx_fifo_re      = 1'b0;
    idle_expired    = 1'b0;
    tx_fifo_we      = 1'b0;
    tx_fifo_wr_data = 8'h00;

    rx_fifo_re   = ((state == IDLE) || frame_st) && rx_fifo_ne && !pop_block && !abort_err;
    idle_expired = frame_st && !rx_fifo_re && (idle_cnt == IDLE_TIMEOUT - 24'd1);
    tx_fifo_we   = (state == RESP) && !tx_fifo_full;
    if (state == RESP) tx_fifo_wr_data = resp_buf[31:24];

    case (state)
      IDLE: begin
        if (rx_fifo_re) begin
          if (rx_fifo_rd_data == OP_WRITE || rx_fifo_rd_data == OP_READ) state_d = ADDR_HI;
          else state_d = RESP;
        end
      end
      ADDR_HI: begin
        if (abort_err || idle_expired) state_d = IDLE;
        else if (rx_fifo_re)           state_d = ADDR_LO;
      end
      ADDR_LO: begin
        if (abort_err || idle_expired) state_d = IDLE;
        else if (rx_fifo_re)           state_d = bus_we ? DATA : BUS;
      end
      DATA: begin
        if (abort_err || idle_expired)         state_d = IDLE;
        else if (rx_fifo_re && byte_cnt == 2'd0) state_d = BUS;
      end
      BUS: begin
        if (ack_hit || bus_expired) state_d = RESP;
      end
      RESP: begin
        if (tx_fifo_we && resp_left == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame capture, timeout counters, bus handshake and response shifter.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      pop_block <= 1'b0;
      idle_cnt  <= 24'd0;
      bus_cnt   <= 16'd0;
      byte_cnt  <= 2'd0;
      addr_raw  <= 16'd0;
      resp_buf  <= 32'd0;
      resp_left <= 3'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_wdata <= 32'd0;
    end else begin
      pop_block <= rx_fifo_re;

      if (!frame_st || rx_fifo_re) idle_cnt <= 24'd0;
      else                         idle_cnt <= idle_cnt + 24'd1;

      if (rx_fifo_re) begin
        case (state)
          IDLE: begin
            bus_we    <= (rx_fifo_rd_data == OP_WRITE);
            resp_buf  <= {RSP_BADOP, 24'h000000};
            resp_left <= 3'd1;
          end
          ADDR_HI: addr_raw[15:8] <= rx_fifo_rd_data;
          ADDR_LO: begin
            addr_raw[7:0] <= rx_fifo_rd_data;
            byte_cnt      <= 2'd3;
          end
          DATA: begin
            bus_wdata <= {bus_wdata[23:0], rx_fifo_rd_data};
            byte_cnt  <= byte_cnt - 2'd1;
          end
          default: ;
        endcase
      end

      if (state == BUS) begin
        if (ack_hit) begin
          bus_req   <= 1'b0;
          resp_buf  <= bus_we ? {RSP_OK, 24'h000000} : bus_rdata;
          resp_left <= bus_we ? 3'd1 : 3'd4;
        end else if (bus_expired) begin
          bus_req   <= 1'b0;
          resp_buf  <= {RSP_TIMEOUT, 24'h000000};
          resp_left <= 3'd1;
        end else if (bus_req) begin
          bus_cnt <= bus_cnt + 16'd1;
        end else begin
          bus_req <= 1'b1;
          bus_cnt <= 16'd0;
        end
      end

      if (tx_fifo_we) begin
        resp_buf  <= {resp_buf[23:0], 8'h00};
        resp_left <= resp_left - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench with rx FIFO/bus models and scoreboards for bus transactions and tx bytes.
module tb_uart_bus_bridge;
  import uart_bridge_pkg::*;

  localparam logic [23:0] TB_IDLE_TO = 24'd100;
  localparam logic [15:0] TB_BUS_TO  = 16'd40;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        reset_l = 1'b1;
  logic [7:0]  rx_fifo_rd_data = 8'h00;
  logic        rx_fifo_ne = 1'b0;
  logic        rx_fifo_re;
  logic        uart_frame_error = 1'b0;
  logic [7:0]  tx_fifo_wr_data;
  logic        tx_fifo_we;
  logic        tx_fifo_full = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int total = 0;
  int bad = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  bus_exp_t   exp_bus[$];

  bit          ack_enable = 1'b1;
  bit          force_ack = 1'b0;
  int          ack_delay = 3;
  logic [31:0] rdata_next = 32'd0;
  int          model_cnt = 0;

  int  tx_seen = 0;
  int  bus_starts = 0;
  int  req_run = 0;
  int  last_run = 0;
  bit  req_prev = 1'b0;

  uart_bus_bridge #(
    .ADDR_WIDTH(16),
    .IDLE_TIMEOUT(TB_IDLE_TO),
    .BUS_TIMEOUT(TB_BUS_TO)
  ) dut (
    .clk(clk),
    .reset_l(reset_l),
    .rx_fifo_rd_data(rx_fifo_rd_data),
    .rx_fifo_ne(rx_fifo_ne),
    .rx_fifo_re(rx_fifo_re),
    .uart_frame_error(uart_frame_error),
    .tx_fifo_wr_data(tx_fifo_wr_data),
    .tx_fifo_we(tx_fifo_we),
    .tx_fifo_full(tx_fifo_full),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    rx_q.push_back(b0);
    rx_q.push_back(b1);
    rx_q.push_back(b2);
  endtask

  task automatic expect_read(input logic [15:0] addr, input logic [31:0] rdata);
    bus_exp_t e;
    e.we = 1'b0;
    e.addr = addr;
    e.wdata = 32'd0;
    exp_bus.push_back(e);
    exp_tx.push_back(rdata[31:24]);
    exp_tx.push_back(rdata[23:16]);
    exp_tx.push_back(rdata[15:8]);
    exp_tx.push_back(rdata[7:0]);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_bus.size() == 0 && rx_q.size() == 0) break;
    end
    repeat (4) @(negedge clk);
    check_output(tag, exp_tx.size() + exp_bus.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_re"}, rx_fifo_re, 0);
    check_output({tag, "_we"}, tx_fifo_we, 0);
    check_output({tag, "_wdat"}, tx_fifo_wr_data, 0);
    check_output({tag, "_req"}, bus_req, 0);
    check_output({tag, "_bwe"}, bus_we, 0);
    check_output({tag, "_addr"}, bus_addr, 0);
    check_output({tag, "_bwd"}, bus_wdata, 0);
  endtask

  // Show-ahead rx FIFO: head/flag refresh on the falling edge, pop on the rising edge.
  always @(negedge clk) begin
    rx_fifo_ne = (rx_q.size() != 0);
    rx_fifo_rd_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (rx_fifo_re && rx_q.size() != 0) void'(rx_q.pop_front());
  end

  always @(negedge clk) begin
    bus_ack = force_ack;
    if (bus_req) begin
      model_cnt++;
      if (ack_enable && model_cnt == ack_delay) begin
        bus_ack = 1'b1;
        bus_rdata = rdata_next;
      end
    end else begin
      model_cnt = 0;
    end
  end

  // Output monitor samples just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (reset_l) begin
      if (tx_fifo_full) check_output("we_while_full", tx_fifo_we, 0);
      if (tx_fifo_we) begin
        tx_seen++;
        if (exp_tx.size() == 0) check_output("tx_extra", exp_tx.size(), 1);
        else check_output("tx_byte", tx_fifo_wr_data, exp_tx.pop_front());
      end
      if (bus_req && !req_prev) begin
        bus_starts++;
        if (exp_bus.size() == 0) check_output("bus_extra", exp_bus.size(), 1);
        else begin
          bus_exp_t e;
          e = exp_bus.pop_front();
          check_output("bus_we", bus_we, e.we);
          check_output("bus_addr", bus_addr, e.addr);
          if (e.we) check_output("bus_wdata", bus_wdata, e.wdata);
        end
      end
      if (bus_req) req_run++;
      else if (req_prev) begin
        last_run = req_run;
        req_run = 0;
      end
      req_prev = bus_req;
    end else begin
      req_prev = 1'b0;
      req_run = 0;
    end
  end

  initial begin
    bus_exp_t w;
    int starts0;
    int seen0;

    #1 reset_l = 1'b0;
    repeat (3) @(negedge clk);
    #4 check_reset_outputs("reset");
    @(negedge clk);
    reset_l = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] write frame");
    w.we = 1'b1;
    w.addr = 16'h1234;
    w.wdata = 32'hDEADBEEF;
    exp_bus.push_back(w);
    exp_tx.push_back(RSP_OK);
    ack_delay = 3;
    apply_stimulus(8'h57, 8'h12, 8'h34);
    rx_q.push_back(8'hDE);
    rx_q.push_back(8'hAD);
    rx_q.push_back(8'hBE);
    rx_q.push_back(8'hEF);
    wait_drain("write_drain");

    $display("[TB] read frame");
    rdata_next = 32'hCAFEF00D;
    expect_read(16'h0010, 32'hCAFEF00D);
    apply_stimulus(8'h52, 8'h00, 8'h10);
    wait_drain("read_drain");

    $display("[TB] bad opcode then read");
    starts0 = bus_starts;
    rdata_next = 32'h01020304;
    exp_tx.push_back(RSP_BADOP);
    expect_read(16'h0004, 32'h01020304);
    rx_q.push_back(8'h41);
    apply_stimulus(8'h52, 8'h00, 8'h04);
    wait_drain("badop_drain");
    check_output("badop_bus_count", bus_starts - starts0, 1);

    $display("[TB] idle timeout");
    starts0 = bus_starts;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h12);
    repeat (int'(TB_IDLE_TO) + 30) @(negedge clk);
    rdata_next = 32'h55AA0FF0;
    expect_read(16'h0000, 32'h55AA0FF0);
    apply_stimulus(8'h52, 8'h00, 8'h00);
    wait_drain("idle_to_drain");
    check_output("idle_to_bus_count", bus_starts - starts0, 1);

    $display("[TB] frame error abort");
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h12);
    repeat (8) @(negedge clk);
    uart_frame_error = 1'b1;
    @(negedge clk);
    uart_frame_error = 1'b0;
    rdata_next = 32'h0BADF00D;
    expect_read(16'h0040, 32'h0BADF00D);
    apply_stimulus(8'h52, 8'h00, 8'h40);
    wait_drain("ferr_drain");

    $display("[TB] bus timeout");
    ack_enable = 1'b0;
    seen0 = tx_seen;
    w.we = 1'b0;
    w.addr = 16'h0008;
    w.wdata = 32'd0;
    exp_bus.push_back(w);
    exp_tx.push_back(RSP_TIMEOUT);
    apply_stimulus(8'h52, 8'h00, 8'h08);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_starts > 0 && !bus_req && req_prev == 1'b0 && exp_bus.size() == 0) break;
    end
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    wait_drain("bus_to_drain");
    check_output("bus_to_req_len", last_run, int'(TB_BUS_TO));
    check_output("bus_to_tx_count", tx_seen - seen0, 1);
    ack_enable = 1'b1;

    $display("[TB] tx backpressure");
    seen0 = tx_seen;
    rdata_next = 32'h11223344;
    expect_read(16'h0020, 32'h11223344);
    apply_stimulus(8'h52, 8'h00, 8'h20);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_seen != seen0) break;
    end
    tx_fifo_full = 1'b1;
    repeat (10) @(negedge clk);
    tx_fifo_full = 1'b0;
    wait_drain("bp_drain");
    check_output("bp_tx_count", tx_seen - seen0, 4);

    $display("[TB] reset mid-DATA");
    seen0 = tx_seen;
    starts0 = bus_starts;
    rx_q.push_back(8'h57);
    apply_stimulus(8'h00, 8'h01, 8'hAA);
    repeat (12) @(negedge clk);
    reset_l = 1'b0;
    #4 check_reset_outputs("midreset");
    rx_q.delete();
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    repeat (60) @(negedge clk);
    check_output("midreset_tx", tx_seen - seen0, 0);
    check_output("midreset_bus", bus_starts - starts0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
